adxl357_init_sequencer: RTL and testbench

- Power-up configuration and run-mode sequencer for the pull-up I2C ADXL357 controller.
- Drives the controller's control word, device address, register address and write data through a fixed init table, and checks the device ID.
- On success, hands the controller over to hardware data-ready-triggered 11-byte burst mode.
- Sits between the top-level sensor wrapper and the I2C controller; no CPU needed for bring-up.

---
 rtl/adxl357_seq_pkg.sv | 53 +++++
 rtl/adxl357_seq_timer.sv | 26 ++
 rtl/adxl357_init_sequencer.sv | 178 +++++++++++++++++
 tb/tb_adxl357_init_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl357_seq_pkg.sv
// Shared types and constants for the ADXL357 power-up sequencer: FSM states,
// controller control-word layout, register map and the fixed init table.
package adxl357_seq_pkg;

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_LOAD,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CHECK,
        S_POST_RST,
        S_RETRY,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [1:0] OP_CPU_1  = 2'b00;
    localparam logic [1:0] OP_CPU_11 = 2'b01;
    localparam logic [1:0] OP_HW_11  = 2'b10;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_RW      = 1;
    localparam int CTRL_OP_LSB  = 2;
    localparam int CTRL_CLK_LSB = 4;

    localparam logic [7:0] REG_DEVID_AD  = 8'h00;
    localparam logic [7:0] REG_FILTER    = 8'h28;
    localparam logic [7:0] REG_RANGE     = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] REG_RESET     = 8'h2F;

    localparam logic [7:0] DEVID_AD   = 8'hAD;
    localparam logic [7:0] RESET_CODE = 8'h52;

    // For read entries the data field holds the value the read must return.
    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } init_entry_t;

    localparam int INIT_LEN = 5;

    localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
        '{1'b0, REG_RESET,     RESET_CODE},
        '{1'b1, REG_DEVID_AD,  DEVID_AD},
        '{1'b0, REG_RANGE,     8'h01},
        '{1'b0, REG_FILTER,    8'h04},
        '{1'b0, REG_POWER_CTL, 8'h00}
    };

endpackage

// File: rtl/adxl357_seq_timer.sv
// Shared delay / timeout counter: counts up from zero after a clear, saturates
// at all-ones, and flags done once the count reaches the supplied limit.
module adxl357_seq_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count >= limit);

endmodule

// File: rtl/adxl357_init_sequencer.sv
// Walks the I2C controller through the ADXL357 init table, verifies the device
// ID, then hands the controller over to DRDY-triggered hardware burst mode.
module adxl357_init_sequencer
    import adxl357_seq_pkg::*;
#(
    parameter int unsigned PWRUP_CYC   = 500000,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [2:0]  CLK_RATE    = 3'd6,
    parameter logic [6:0]  DEV_ADDR    = 7'h1D
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_restart,
    input  logic [31:0] i_status,
    input  logic [31:0] i_accx,
    input  logic        i_drdy,
    output logic [31:0] o_ctrl,
    output logic [6:0]  o_dev_addr,
    output logic [7:0]  o_reg_addr,
    output logic [7:0]  o_w_data,
    output logic        o_drdy,
    output logic        o_init_done,
    output logic        o_fail,
    output logic [2:0]  o_step,
    output logic [1:0]  o_retry_cnt
);

    state_t      state;
    logic [2:0]  step;
    logic [1:0]  retry;
    logic        enable;
    logic        rw_reg;
    logic [1:0]  op_mode;
    logic        tmr_clear;
    logic        tmr_done;
    logic [19:0] tmr_limit;
    init_entry_t cur;
    logic        ready;
    logic [7:0]  ctl_state;
    logic [7:0]  rd_byte;
    logic        unused_bits;

    assign ready       = i_status[0];
    assign ctl_state   = i_status[9:2];
    assign rd_byte     = i_accx[19:12];
    assign cur         = INIT_TABLE[step];
    assign unused_bits = &{1'b0, i_status[31:10], i_status[1], i_accx[31:20], i_accx[11:0]};

    assign o_dev_addr  = DEV_ADDR;
    assign o_step      = step;
    assign o_retry_cnt = retry;

    always_comb begin
        o_ctrl                      = '0;
        o_ctrl[CTRL_EN]             = enable;
        o_ctrl[CTRL_RW]             = rw_reg;
        o_ctrl[CTRL_OP_LSB +: 2]    = op_mode;
        o_ctrl[CTRL_CLK_LSB +: 3]   = CLK_RATE;
    end

    // The timer restarts on every phase boundary so each wait is measured from its own start.
    always_comb begin
        tmr_limit = (state == S_PWR_WAIT || state == S_POST_RST) ? 20'(PWRUP_CYC - 1)
                                                                 : 20'(TIMEOUT_CYC - 1);
        tmr_clear = i_restart
                 || state inside {S_LOAD, S_CHECK, S_RETRY, S_RUN, S_FAIL}
                 || (state == S_ISSUE && ready)
                 || (state == S_WAIT_BUSY && !ready);
    end

    adxl357_seq_timer #(.WIDTH(20)) u_timer (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (tmr_clear),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_PWR_WAIT;
            step        <= '0;
            retry       <= '0;
            enable      <= 1'b0;
            rw_reg      <= 1'b0;
            op_mode     <= OP_CPU_1;
            o_reg_addr  <= '0;
            o_w_data    <= '0;
            o_drdy      <= 1'b0;
            o_init_done <= 1'b0;
            o_fail      <= 1'b0;
        end else if (i_restart) begin
            state       <= S_PWR_WAIT;
            step        <= '0;
            retry       <= '0;
            enable      <= 1'b0;
            op_mode     <= OP_CPU_1;
            o_drdy      <= 1'b0;
            o_init_done <= 1'b0;
            o_fail      <= 1'b0;
        end else begin
            case (state)
                S_PWR_WAIT: if (tmr_done) state <= S_LOAD;
                S_LOAD: begin
                    o_reg_addr <= cur.addr;
                    o_w_data   <= cur.rd ? 8'h00 : cur.data;
                    op_mode    <= OP_CPU_1;
                    rw_reg     <= cur.rd;
                    enable     <= 1'b0;
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (ready) begin
                        enable <= 1'b1;
                        state  <= S_WAIT_BUSY;
                    end else if (tmr_done) begin
                        state  <= S_RETRY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!ready) begin
                        enable <= 1'b0;
                        state  <= S_WAIT_DONE;
                    end else if (tmr_done) begin
                        enable <= 1'b0;
                        state  <= S_RETRY;
                    end
                end
                S_WAIT_DONE: begin
                    if (ready && ctl_state == 8'h00) state <= S_CHECK;
                    else if (tmr_done)               state <= S_RETRY;
                end
                S_CHECK: begin
                    if (cur.rd && rd_byte != cur.data) begin
                        state <= S_RETRY;
                    end else if (step == 3'd0) begin
                        state <= S_POST_RST;
                    end else if (step == 3'(INIT_LEN - 1)) begin
                        op_mode     <= OP_HW_11;
                        rw_reg      <= 1'b1;
                        enable      <= 1'b0;
                        o_drdy      <= 1'b0;
                        o_init_done <= 1'b1;
                        state       <= S_RUN;
                    end else begin
                        step  <= step + 3'd1;
                        state <= S_LOAD;
                    end
                end
                S_POST_RST: begin
                    if (tmr_done) begin
                        step  <= 3'd1;
                        state <= S_LOAD;
                    end
                end
                S_RETRY: begin
                    enable <= 1'b0;
                    if (retry == 2'(MAX_RETRY)) begin
                        o_fail <= 1'b1;
                        state  <= S_FAIL;
                    end else begin
                        retry <= retry + 2'd1;
                        step  <= '0;
                        state <= S_PWR_WAIT;
                    end
                end
                S_RUN:  o_drdy <= i_drdy;
                S_FAIL: begin
                    enable <= 1'b0;
                    o_drdy <= 1'b0;
                end
                default: state <= S_PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_adxl357_init_sequencer.sv
// Self-checking bench: behavioural I2C controller model with a transaction
// scoreboard, a DRDY vector table and directed multi-cycle corner cases.
module tb_adxl357_init_sequencer;

    localparam int PWRUP = 100;
    localparam int TMO   = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        drdy_in = 1'b0;
    logic [31:0] status = 32'h1;
    logic [31:0] accx = 32'h0;
    logic [31:0] o_ctrl;
    logic [6:0]  o_dev_addr;
    logic [7:0]  o_reg_addr;
    logic [7:0]  o_w_data;
    logic        o_drdy;
    logic        o_init_done;
    logic        o_fail;
    logic [2:0]  o_step;
    logic [1:0]  o_retry_cnt;

    always #5 clk = ~clk;

    adxl357_init_sequencer #(
        .PWRUP_CYC   (PWRUP),
        .TIMEOUT_CYC (TMO),
        .MAX_RETRY   (3),
        .CLK_RATE    (3'd6),
        .DEV_ADDR    (7'h1D)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_restart   (restart),
        .i_status    (status),
        .i_accx      (accx),
        .i_drdy      (drdy_in),
        .o_ctrl      (o_ctrl),
        .o_dev_addr  (o_dev_addr),
        .o_reg_addr  (o_reg_addr),
        .o_w_data    (o_w_data),
        .o_drdy      (o_drdy),
        .o_init_done (o_init_done),
        .o_fail      (o_fail),
        .o_step      (o_step),
        .o_retry_cnt (o_retry_cnt)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard of transactions the controller model expects to be asked for.
    typedef struct {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t exp_q[$];

    task automatic push_steps(input int count);
        txn_t seq [5];
        seq[0] = '{1'b0, 8'h2F, 8'h52};
        seq[1] = '{1'b1, 8'h00, 8'h00};
        seq[2] = '{1'b0, 8'h2C, 8'h01};
        seq[3] = '{1'b0, 8'h28, 8'h04};
        seq[4] = '{1'b0, 8'h2D, 8'h00};
        for (int i = 0; i < count; i++) exp_q.push_back(seq[i]);
    endtask

    // Behavioural controller: goes busy on enable, returns to idle/ready later.
    logic [7:0] model_id = 8'hAD;
    bit         stuck = 1'b0;
    bit         busy = 1'b0;
    bit         busy_rd = 1'b0;
    int         busy_cnt = 0;
    txn_t       got;

    always @(negedge clk) begin
        if (rst) begin
            busy     = 1'b0;
            busy_cnt = 0;
        end else if (!busy) begin
            if (o_ctrl[0] && !stuck) begin
                busy     = 1'b1;
                busy_rd  = o_ctrl[1];
                busy_cnt = o_ctrl[1] ? 6 : 4;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_txn: actual=%0h required=none", o_reg_addr);
                end else begin
                    got = exp_q.pop_front();
                    check("txn_rw", 32'(o_ctrl[1]), 32'(got.rd));
                    check("txn_reg", 32'(o_reg_addr), 32'(got.addr));
                    check("txn_opmode", 32'(o_ctrl[3:2]), 32'h0);
                    if (!got.rd) check("txn_wdata", 32'(o_w_data), 32'(got.data));
                end
            end
        end else begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                busy = 1'b0;
                if (busy_rd) accx = {12'h0, model_id, 12'h0};
            end
        end
        status = {22'h0, (busy ? 8'h05 : 8'h00), 1'b0, ~busy};
    end

    // DRDY vectors: phase 0 = before RUN, 1 = RUN, 2 = FAIL.
    typedef struct {
        int   phase;
        logic drdy;
        logic exp_drdy;
    } vec_t;

    vec_t vecs[$];

    task automatic apply_vecs(input int phase);
        foreach (vecs[i]) begin
            if (vecs[i].phase == phase) begin
                @(negedge clk);
                drdy_in = vecs[i].drdy;
                @(posedge clk);
                #1;
                check($sformatf("drdy_p%0d_v%0d", phase, i), 32'(o_drdy), 32'(vecs[i].exp_drdy));
            end
        end
        @(negedge clk);
        drdy_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, o_ctrl, 32'h0000_0060);
        check({tag, "_dev_addr"}, 32'(o_dev_addr), 32'h1D);
        check({tag, "_reg_addr"}, 32'(o_reg_addr), 32'h0);
        check({tag, "_w_data"}, 32'(o_w_data), 32'h0);
        check({tag, "_drdy"}, 32'(o_drdy), 32'h0);
        check({tag, "_init_done"}, 32'(o_init_done), 32'h0);
        check({tag, "_fail"}, 32'(o_fail), 32'h0);
        check({tag, "_step"}, 32'(o_step), 32'h0);
        check({tag, "_retry"}, 32'(o_retry_cnt), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        restart = 1'b0;
        drdy_in = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded wait: 0 = init_done, 1 = fail, 2 = enable, 3 = model busy on step 3.
    task automatic wait_for(input int which, input int budget, input string name);
        int  n   = 0;
        bit  hit = 1'b0;
        while (n < budget && !hit) begin
            @(posedge clk);
            #1;
            n++;
            case (which)
                0:       hit = o_init_done;
                1:       hit = o_fail;
                2:       hit = o_ctrl[0];
                default: hit = busy && (o_step == 3'd3);
            endcase
        end
        check(name, 32'(hit), 32'h1);
    endtask

    initial begin
        int n;

        vecs.push_back('{0, 1'b1, 1'b0});
        vecs.push_back('{0, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b1, 1'b0});
        vecs.push_back('{1, 1'b1, 1'b1});
        vecs.push_back('{1, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b1, 1'b1});
        vecs.push_back('{1, 1'b1, 1'b1});
        vecs.push_back('{1, 1'b0, 1'b0});
        vecs.push_back('{2, 1'b1, 1'b0});
        vecs.push_back('{2, 1'b0, 1'b0});
        vecs.push_back('{2, 1'b1, 1'b0});

        // Normal bring-up.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        push_steps(5);
        apply_vecs(0);
        wait_for(0, 2000, "bringup_done");
        check("bringup_ctrl", o_ctrl, 32'h0000_006A);
        check("bringup_step", 32'(o_step), 32'h4);
        check("bringup_retry", 32'(o_retry_cnt), 32'h0);
        check("bringup_sb_empty", 32'(exp_q.size()), 32'h0);
        apply_vecs(1);

        // Reset and restart together in RUN: reset wins, then PWR_WAIT length.
        @(negedge clk);
        rst     = 1'b1;
        restart = 1'b1;
        drdy_in = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_restart");
        @(negedge clk);
        rst     = 1'b0;
        restart = 1'b0;
        drdy_in = 1'b0;
        n = 0;
        while (n < 300 && o_reg_addr != 8'h2F) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pwr_wait_len", 32'(n), 32'(PWRUP + 1));

        // ID mismatch on every read: four full attempts, then FAIL.
        do_reset();
        model_id = 8'hAC;
        for (int i = 0; i < 4; i++) push_steps(2);
        wait_for(1, 3000, "idfail_fail");
        check("idfail_retry", 32'(o_retry_cnt), 32'h3);
        check("idfail_done", 32'(o_init_done), 32'h0);
        check("idfail_enable", 32'(o_ctrl[0]), 32'h0);
        check("idfail_sb_empty", 32'(exp_q.size()), 32'h0);
        apply_vecs(2);

        // Ready never drops after enable: WAIT_BUSY timeout then retry.
        do_reset();
        model_id = 8'hAD;
        stuck    = 1'b1;
        wait_for(2, 400, "tmo_enable_seen");
        n = 0;
        while (n < 200 && o_ctrl[0]) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tmo_enable_len", 32'(n), 32'(TMO));
        check("tmo_enable_low", 32'(o_ctrl[0]), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("tmo_retry", 32'(o_retry_cnt), 32'h1);
        check("tmo_step", 32'(o_step), 32'h0);
        stuck = 1'b0;
        push_steps(5);
        wait_for(0, 2000, "tmo_recover_done");
        check("tmo_recover_retry", 32'(o_retry_cnt), 32'h1);
        check("tmo_sb_empty", 32'(exp_q.size()), 32'h0);

        // Restart while waiting for step 3 to complete.
        do_reset();
        push_steps(4);
        wait_for(3, 2000, "rs_step3_busy");
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check("rs_step", 32'(o_step), 32'h0);
        check("rs_enable", 32'(o_ctrl[0]), 32'h0);
        check("rs_done", 32'(o_init_done), 32'h0);
        push_steps(5);
        wait_for(0, 2000, "rs_rerun_done");
        check("rs_retry", 32'(o_retry_cnt), 32'h0);
        check("rs_ctrl", o_ctrl, 32'h0000_006A);
        check("rs_sb_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
